ccip_txn_tracker: RTL and testbench
===================================

CCIP_TXN_TRACKER -- requirements
Module: ccip_txn_tracker

Interface
REQ-001 Parameter NUM_CH, default 2: number of independently tracked request/response channel pairs (1..4); ch0 = C0 read, ch1 = C1 write.
REQ-002 Parameter TAG_WIDTH, default 6: mdata low bits used as tracking tag; table depth per channel = 2**TAG_WIDTH.
REQ-003 Parameter TS_WIDTH, default 16: timestamp and latency width.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: outstanding age, in cycles, that raises a timeout; must be less than 2**TS_WIDTH.
REQ-005 Parameter CNT_WIDTH, default 32: statistics counter width.
REQ-006 clk  in  1  sole clock; all logic on posedge.
REQ-007 SoftReset_n  in  1  synchronous active-low reset.
REQ-008 clear_stats  in  1  synchronous clear of counters and max latency only.
REQ-009 req_valid  in  NUM_CH  request issued on channel c.
REQ-010 req_tag  in  NUM_CH*TAG_WIDTH  request tag, channel c at slice c.
REQ-011 req_len  in  NUM_CH*2  ccip_len_t; expected responses = len+1.
REQ-012 rsp_valid  in  NUM_CH  one response beat on channel c.
REQ-013 rsp_tag  in  NUM_CH*TAG_WIDTH  response tag.
REQ-014 outstanding  out  NUM_CH*(TAG_WIDTH+1)  live entries per channel.
REQ-015 req_count, rsp_count  out  NUM_CH*CNT_WIDTH each  accepted requests / response beats.
REQ-016 max_latency  out  NUM_CH*TS_WIDTH  worst issue-to-final-response cycles.
REQ-017 err_dup, err_orphan, err_timeout  out  NUM_CH each  single-cycle error pulses.
REQ-018 err_tag  out  NUM_CH*TAG_WIDTH  tag of the error pulsed this cycle (priority orphan > dup > timeout).
REQ-019 idle  out  1  high when every channel has outstanding == 0.

Function
REQ-020 Each table entry holds valid, 2-bit remaining-beat count and TS_WIDTH issue timestamp.
REQ-021 Request on free tag: entry valid, remaining = len, timestamp = free-running cycle counter; visible in outstanding next cycle.
REQ-022 Request on valid tag: err_dup pulse next cycle; entry unchanged; req_count still increments.
REQ-023 Response on valid tag with remaining > 0: remaining decrements; entry stays.
REQ-024 Response on valid tag with remaining == 0: entry freed; latency = now - timestamp, modulo 2**TS_WIDTH; max_latency updated if greater.
REQ-025 Response on invalid tag: err_orphan pulse next cycle; no state change besides rsp_count.
REQ-026 Same-cycle response and request on same channel and tag: response processed first, then request; no err_dup if response retires the entry.
REQ-027 Timeout scanner per channel: index 0..2**TAG_WIDTH-1, one entry per cycle, wraps to 0; valid entry with age >= TIMEOUT_CYCLES pulses err_timeout and frees entry.
REQ-028 Scanner skips the entry if a request or response hits the same tag that cycle; the entry is rechecked next lap.
REQ-029 Counters saturate at all-ones; clear_stats has priority over same-cycle increments.
REQ-030 All error and statistic outputs are registered: one-cycle latency from the input event.

Reset
REQ-031 SoftReset_n low at posedge clears all valid bits, scanner indices, cycle counter, counters, max_latency, error pulses; idle = 1.
REQ-032 Reset asserted mid-transaction discards outstanding state silently; responses after reset report err_orphan.

Configuration
REQ-033 CCIP_TRACKER_LATENCY_EN defined: timestamps, max_latency and timeout scanner present.
REQ-034 CCIP_TRACKER_LATENCY_EN undefined: no timestamp storage; max_latency and err_timeout tied 0; all other behaviour identical.

Structure
REQ-035 ase_pkg holds tracker_entry_t (valid, remaining, ts) and the tracker error-code enum; ccip_len_t is reused from ase_pkg.
REQ-036 Per-channel logic lives in sub-module ccip_tracker_chan, instantiated NUM_CH times by a generate loop; the top holds the shared cycle counter and idle reduction.

Verification
REQ-037 ch0 req tag 5 len ASE_1CL at T, rsp tag 5 at T+10 -> outstanding 1 then 0, max_latency 10, idle high at T+11.
REQ-038 ch1 req tag 3 len ASE_4CL, 4 rsp beats tag 3 -> entry freed only after the 4th beat, rsp_count 4, req_count 1.
REQ-039 rsp tag 9 with no request -> err_orphan[0] one cycle, err_tag 9; req tag 2 twice -> err_dup, outstanding 1.
REQ-040 Same cycle: rsp retiring tag 7 plus new req tag 7 -> no err_dup, outstanding unchanged at 1.
REQ-041 TIMEOUT_CYCLES 100, req tag 1 with no rsp -> err_timeout within 100+2**TAG_WIDTH cycles, outstanding 0; then SoftReset_n low with 3 live entries -> all outputs at reset values and idle 1 next cycle.

Source files
------------

// File: rtl/ase_pkg.sv
// Shared CCI-P types for the transaction tracker: request length, table entry and error codes.
package ase_pkg;

  typedef enum logic [1:0] {
    ASE_1CL = 2'b00,
    ASE_2CL = 2'b01,
    ASE_3CL = 2'b10,
    ASE_4CL = 2'b11
  } ccip_len_t;

  localparam int TRK_TS_WIDTH = 16;

  typedef struct packed {
    logic                    valid;
    logic [1:0]              remaining;
    logic [TRK_TS_WIDTH-1:0] ts;
  } tracker_entry_t;

  typedef enum logic [1:0] {
    TRK_ERR_NONE    = 2'd0,
    TRK_ERR_ORPHAN  = 2'd1,
    TRK_ERR_DUP     = 2'd2,
    TRK_ERR_TIMEOUT = 2'd3
  } trackerErr_t;

endpackage

// File: rtl/ccip_tracker_chan.sv
// One request/response channel: tag table, error detection, statistics and timeout scanner.
// Timestamps, max latency and the scanner exist only when CCIP_TRACKER_LATENCY_EN is defined.
module ccip_tracker_chan
  import ase_pkg::*;
#(
  parameter int TAG_WIDTH      = 6,
  parameter int TS_WIDTH       = 16,
`ifdef CCIP_TRACKER_LATENCY_EN
  parameter int TIMEOUT_CYCLES = 4096,
`endif
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 SoftReset_n,
  input  logic                 clearStats,
`ifdef CCIP_TRACKER_LATENCY_EN
  input  logic [TS_WIDTH-1:0]  cycleNow,
`endif
  input  logic                 reqValid,
  input  logic [TAG_WIDTH-1:0] reqTag,
  input  ccip_len_t            reqLen,
  input  logic                 rspValid,
  input  logic [TAG_WIDTH-1:0] rspTag,
  output logic [TAG_WIDTH:0]   outstanding,
  output logic [CNT_WIDTH-1:0] reqCount,
  output logic [CNT_WIDTH-1:0] rspCount,
  output logic [TS_WIDTH-1:0]  maxLatency,
  output logic                 errDup,
  output logic                 errOrphan,
  output logic                 errTimeout,
  output logic [TAG_WIDTH-1:0] errTag
);

  localparam int DEPTH = 1 << TAG_WIDTH;

  logic [DEPTH-1:0]     entValid;
  logic [1:0]           entRem [DEPTH];
  logic                 rspHit, rspLast, isOrphan, reqBusy, isDup, doAlloc, isTimeout;
  logic [TAG_WIDTH-1:0] scanTag, nextTag;
  trackerErr_t          errCode;

  // The response is applied before the request, so a retiring beat frees the tag for reuse.
  assign rspHit   = rspValid && entValid[rspTag];
  assign rspLast  = rspHit && (entRem[rspTag] == 2'd0);
  assign isOrphan = rspValid && !entValid[rspTag];
  assign reqBusy  = entValid[reqTag] && !(rspLast && (rspTag == reqTag));
  assign isDup    = reqValid && reqBusy;
  assign doAlloc  = reqValid && !reqBusy;

  always_comb begin
    errCode = TRK_ERR_NONE;
    if (isOrphan)       errCode = TRK_ERR_ORPHAN;
    else if (isDup)     errCode = TRK_ERR_DUP;
    else if (isTimeout) errCode = TRK_ERR_TIMEOUT;
    case (errCode)
      TRK_ERR_ORPHAN:  nextTag = rspTag;
      TRK_ERR_DUP:     nextTag = reqTag;
      TRK_ERR_TIMEOUT: nextTag = scanTag;
      default:         nextTag = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      entValid    <= '0;
      outstanding <= '0;
      reqCount    <= '0;
      rspCount    <= '0;
      errDup      <= 1'b0;
      errOrphan   <= 1'b0;
      errTimeout  <= 1'b0;
      errTag      <= '0;
    end else begin
      if (isTimeout) entValid[scanTag] <= 1'b0;
      if (rspLast)   entValid[rspTag]  <= 1'b0;
      if (doAlloc)   entValid[reqTag]  <= 1'b1;
      outstanding <= outstanding + (TAG_WIDTH+1)'(doAlloc)
                     - (TAG_WIDTH+1)'(rspLast) - (TAG_WIDTH+1)'(isTimeout);
      errDup     <= isDup;
      errOrphan  <= isOrphan;
      errTimeout <= isTimeout;
      errTag     <= nextTag;
      if (clearStats)                       reqCount <= '0;
      else if (reqValid && reqCount != '1)  reqCount <= reqCount + CNT_WIDTH'(1);
      if (clearStats)                       rspCount <= '0;
      else if (rspValid && rspCount != '1)  rspCount <= rspCount + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rspHit && !rspLast) entRem[rspTag] <= entRem[rspTag] - 2'd1;
    if (doAlloc)            entRem[reqTag] <= reqLen;
  end

`ifdef CCIP_TRACKER_LATENCY_EN
  logic [TS_WIDTH-1:0]  entTs [DEPTH];
  logic [TAG_WIDTH-1:0] scanIdx;
  logic [TS_WIDTH-1:0]  rspLatency, scanAge;
  logic                 scanSkip;

  // Ages wrap modulo 2**TS_WIDTH, so TIMEOUT_CYCLES must stay below that range.
  assign rspLatency = cycleNow - entTs[rspTag];
  assign scanAge    = cycleNow - entTs[scanIdx];
  assign scanSkip   = (reqValid && (reqTag == scanIdx)) || (rspValid && (rspTag == scanIdx));
  assign isTimeout  = entValid[scanIdx] && !scanSkip && (scanAge >= TS_WIDTH'(TIMEOUT_CYCLES));
  assign scanTag    = scanIdx;

  always_ff @(posedge clk) begin
    if (doAlloc) entTs[reqTag] <= cycleNow;
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      scanIdx    <= '0;
      maxLatency <= '0;
    end else begin
      scanIdx <= scanIdx + TAG_WIDTH'(1);
      if (clearStats)                            maxLatency <= '0;
      else if (rspLast && rspLatency > maxLatency) maxLatency <= rspLatency;
    end
  end
`else
  assign isTimeout  = 1'b0;
  assign scanTag    = '0;
  assign maxLatency = '0;
`endif

endmodule

// File: rtl/ccip_txn_tracker.sv
// CCI-P transaction tracker top: per-channel trackers, shared cycle counter and idle reduction.
// Define CCIP_TRACKER_LATENCY_EN to add timestamps, max latency and the timeout scanner.
module ccip_txn_tracker
  import ase_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TAG_WIDTH      = 6,
  parameter int TS_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                            clk,
  input  logic                            SoftReset_n,
  input  logic                            clear_stats,
  input  logic [NUM_CH-1:0]               req_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]     req_tag,
  input  logic [NUM_CH*2-1:0]             req_len,
  input  logic [NUM_CH-1:0]               rsp_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]     rsp_tag,
  output logic [NUM_CH*(TAG_WIDTH+1)-1:0] outstanding,
  output logic [NUM_CH*CNT_WIDTH-1:0]     req_count,
  output logic [NUM_CH*CNT_WIDTH-1:0]     rsp_count,
  output logic [NUM_CH*TS_WIDTH-1:0]      max_latency,
  output logic [NUM_CH-1:0]               err_dup,
  output logic [NUM_CH-1:0]               err_orphan,
  output logic [NUM_CH-1:0]               err_timeout,
  output logic [NUM_CH*TAG_WIDTH-1:0]     err_tag,
  output logic                            idle
);

  if (NUM_CH < 1 || NUM_CH > 4 ||
      longint'(TIMEOUT_CYCLES) >= (longint'(1) << TS_WIDTH)) begin : gParamCheck
    $error("ccip_txn_tracker: NUM_CH must be 1..4 and TIMEOUT_CYCLES below 2**TS_WIDTH");
  end

`ifdef CCIP_TRACKER_LATENCY_EN
  logic [TS_WIDTH-1:0] cycleNow;

  always_ff @(posedge clk) begin
    if (!SoftReset_n) cycleNow <= '0;
    else              cycleNow <= cycleNow + TS_WIDTH'(1);
  end
`endif

  logic [NUM_CH-1:0] chIdle;

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    ccip_tracker_chan #(
      .TAG_WIDTH      (TAG_WIDTH),
      .TS_WIDTH       (TS_WIDTH),
`ifdef CCIP_TRACKER_LATENCY_EN
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
      .CNT_WIDTH      (CNT_WIDTH)
    ) uChan (
      .clk         (clk),
      .SoftReset_n (SoftReset_n),
      .clearStats  (clear_stats),
`ifdef CCIP_TRACKER_LATENCY_EN
      .cycleNow    (cycleNow),
`endif
      .reqValid    (req_valid[c]),
      .reqTag      (req_tag[c*TAG_WIDTH +: TAG_WIDTH]),
      .reqLen      (ccip_len_t'(req_len[c*2 +: 2])),
      .rspValid    (rsp_valid[c]),
      .rspTag      (rsp_tag[c*TAG_WIDTH +: TAG_WIDTH]),
      .outstanding (outstanding[c*(TAG_WIDTH+1) +: TAG_WIDTH+1]),
      .reqCount    (req_count[c*CNT_WIDTH +: CNT_WIDTH]),
      .rspCount    (rsp_count[c*CNT_WIDTH +: CNT_WIDTH]),
      .maxLatency  (max_latency[c*TS_WIDTH +: TS_WIDTH]),
      .errDup      (err_dup[c]),
      .errOrphan   (err_orphan[c]),
      .errTimeout  (err_timeout[c]),
      .errTag      (err_tag[c*TAG_WIDTH +: TAG_WIDTH])
    );

    assign chIdle[c] = (outstanding[c*(TAG_WIDTH+1) +: TAG_WIDTH+1] == '0);
  end

  assign idle = &chIdle;

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// Self-checking bench for ccip_txn_tracker: directed scenarios plus randomized traffic
// checked against a per-tag behavioural model of outstanding transactions.
module tb_ccip_txn_tracker;
  import ase_pkg::*;

  localparam int NUM_CH = 2, TAG_WIDTH = 6, TS_WIDTH = 16, TIMEOUT_CYCLES = 100, CNT_WIDTH = 32;
  localparam int DEPTH = 1 << TAG_WIDTH;
  localparam int TS_MASK = (1 << TS_WIDTH) - 1;
`ifdef CCIP_TRACKER_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic SoftReset_n, clear_stats, idle;
  logic [NUM_CH-1:0] req_valid, rsp_valid, err_dup, err_orphan, err_timeout;
  logic [NUM_CH*TAG_WIDTH-1:0] req_tag, rsp_tag, err_tag;
  logic [NUM_CH*2-1:0] req_len;
  logic [NUM_CH*(TAG_WIDTH+1)-1:0] outstanding;
  logic [NUM_CH*CNT_WIDTH-1:0] req_count, rsp_count;
  logic [NUM_CH*TS_WIDTH-1:0] max_latency;

  int total = 0, bad = 0;

  // model: what the tracker should know about each tag, plus expected outputs
  bit mLive [NUM_CH][DEPTH];
  int mLeft [NUM_CH][DEPTH];
  int mTs   [NUM_CH][DEPTH];
  int mReqCnt[NUM_CH], mRspCnt[NUM_CH], mMaxLat[NUM_CH], mTag[NUM_CH];
  bit mDup[NUM_CH], mOrph[NUM_CH], mTo[NUM_CH];
  int mCyc;

  ccip_txn_tracker #(
    .NUM_CH(NUM_CH), .TAG_WIDTH(TAG_WIDTH), .TS_WIDTH(TS_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .SoftReset_n(SoftReset_n), .clear_stats(clear_stats),
    .req_valid(req_valid), .req_tag(req_tag), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .outstanding(outstanding), .req_count(req_count), .rsp_count(rsp_count),
    .max_latency(max_latency), .err_dup(err_dup), .err_orphan(err_orphan),
    .err_timeout(err_timeout), .err_tag(err_tag), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int gOut(int c);  return int'(outstanding[c*(TAG_WIDTH+1) +: TAG_WIDTH+1]); endfunction
  function automatic int gReqC(int c); return int'(req_count[c*CNT_WIDTH +: CNT_WIDTH]); endfunction
  function automatic int gRspC(int c); return int'(rsp_count[c*CNT_WIDTH +: CNT_WIDTH]); endfunction
  function automatic int gLat(int c);  return int'(max_latency[c*TS_WIDTH +: TS_WIDTH]); endfunction
  function automatic int gTag(int c);  return int'(err_tag[c*TAG_WIDTH +: TAG_WIDTH]); endfunction

  function automatic int mOut(int c);
    int n = 0;
    for (int t = 0; t < DEPTH; t++) n += int'(mLive[c][t]);
    return n;
  endfunction

  task automatic setReq(int c, int tag, int len);
    req_valid[c] = 1'b1;
    req_tag[c*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(tag);
    req_len[c*2 +: 2] = 2'(len);
  endtask

  task automatic setRsp(int c, int tag);
    rsp_valid[c] = 1'b1;
    rsp_tag[c*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(tag);
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic step();
    int qt, rt, s;
    if (!SoftReset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < DEPTH; t++) mLive[c][t] = 1'b0;
        mReqCnt[c] = 0; mRspCnt[c] = 0; mMaxLat[c] = 0;
        mDup[c] = 0; mOrph[c] = 0; mTo[c] = 0; mTag[c] = 0;
      end
      mCyc = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        qt = int'(req_tag[c*TAG_WIDTH +: TAG_WIDTH]);
        rt = int'(rsp_tag[c*TAG_WIDTH +: TAG_WIDTH]);
        mDup[c] = 0; mOrph[c] = 0; mTo[c] = 0;
        if (rsp_valid[c]) begin
          mRspCnt[c]++;
          if (!mLive[c][rt]) mOrph[c] = 1;
          else if (mLeft[c][rt] > 0) mLeft[c][rt]--;
          else begin
            mLive[c][rt] = 0;
            if (LAT_EN && ((mCyc - mTs[c][rt]) & TS_MASK) > mMaxLat[c])
              mMaxLat[c] = (mCyc - mTs[c][rt]) & TS_MASK;
          end
        end
        if (req_valid[c]) begin
          mReqCnt[c]++;
          if (mLive[c][qt]) mDup[c] = 1;
          else begin
            mLive[c][qt] = 1;
            mLeft[c][qt] = int'(req_len[c*2 +: 2]);
            mTs[c][qt] = mCyc;
          end
        end
        s = mCyc % DEPTH;
        if (LAT_EN && !(req_valid[c] && qt == s) && !(rsp_valid[c] && rt == s) && mLive[c][s]
            && ((mCyc - mTs[c][s]) & TS_MASK) >= TIMEOUT_CYCLES) begin
          mTo[c] = 1;
          mLive[c][s] = 0;
        end
        if (mOrph[c]) mTag[c] = rt;
        else if (mDup[c]) mTag[c] = qt;
        else if (mTo[c]) mTag[c] = s;
        if (clear_stats) begin
          mReqCnt[c] = 0; mRspCnt[c] = 0; mMaxLat[c] = 0;
        end
      end
      mCyc++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_valid = '0;
    clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    SoftReset_n = 1'b0;
    step();
    step();
    for (int c = 0; c < NUM_CH; c++) begin
      total++; if (gOut(c) !== 0) begin bad++; $display("FAIL reset_outstanding ch%0d got=%0d want=0", c, gOut(c)); end
      total++; if (gReqC(c) !== 0 || gRspC(c) !== 0) begin bad++; $display("FAIL reset_counts ch%0d got=%0d/%0d want=0/0", c, gReqC(c), gRspC(c)); end
      total++; if (gLat(c) !== 0) begin bad++; $display("FAIL reset_maxlat ch%0d got=%0d want=0", c, gLat(c)); end
    end
    total++; if ({err_dup, err_orphan, err_timeout} !== '0) begin bad++; $display("FAIL reset_errors got=%b want=0", {err_dup, err_orphan, err_timeout}); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
    SoftReset_n = 1'b1;
  endtask

  task automatic test_latency();
    setReq(0, 5, ASE_1CL);
    step();
    total++; if (gOut(0) !== 1) begin bad++; $display("FAIL lat_outst_issue got=%0d want=1", gOut(0)); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL lat_idle_busy got=%b want=0", idle); end
    repeat (9) step();
    setRsp(0, 5);
    step();
    total++; if (gOut(0) !== 0) begin bad++; $display("FAIL lat_outst_done got=%0d want=0", gOut(0)); end
    total++; if (gLat(0) !== (LAT_EN ? 10 : 0)) begin bad++; $display("FAIL lat_max got=%0d want=%0d", gLat(0), LAT_EN ? 10 : 0); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL lat_idle_done got=%b want=1", idle); end
    clear_stats = 1'b1;
    setReq(0, 6, ASE_1CL);
    step();
    total++; if (gLat(0) !== 0 || gReqC(0) !== 0) begin bad++; $display("FAIL clear_stats got=%0d/%0d want=0/0", gLat(0), gReqC(0)); end
    setRsp(0, 6);
    step();
  endtask

  task automatic test_multi_beat();
    clear_stats = 1'b1;
    step();
    setReq(1, 3, ASE_4CL);
    step();
    for (int b = 0; b < 4; b++) begin
      setRsp(1, 3);
      step();
      total++;
      if (gOut(1) !== ((b < 3) ? 1 : 0)) begin
        bad++; $display("FAIL beat_outst beat%0d got=%0d want=%0d", b, gOut(1), (b < 3) ? 1 : 0);
      end
    end
    total++; if (gRspC(1) !== 4) begin bad++; $display("FAIL beat_rsp_count got=%0d want=4", gRspC(1)); end
    total++; if (gReqC(1) !== 1) begin bad++; $display("FAIL beat_req_count got=%0d want=1", gReqC(1)); end
  endtask

  task automatic test_errors();
    setRsp(0, 9);
    step();
    total++; if (err_orphan[0] !== 1'b1 || gTag(0) !== 9) begin bad++; $display("FAIL orphan got=%b tag=%0d want=1 tag=9", err_orphan[0], gTag(0)); end
    step();
    total++; if (err_orphan[0] !== 1'b0) begin bad++; $display("FAIL orphan_pulse got=%b want=0", err_orphan[0]); end
    setReq(0, 2, ASE_1CL);
    step();
    setReq(0, 2, ASE_1CL);
    step();
    total++; if (err_dup[0] !== 1'b1 || gTag(0) !== 2) begin bad++; $display("FAIL dup got=%b tag=%0d want=1 tag=2", err_dup[0], gTag(0)); end
    total++; if (gOut(0) !== 1) begin bad++; $display("FAIL dup_outst got=%0d want=1", gOut(0)); end
    setRsp(0, 2);
    step();
    total++; if (err_dup[0] !== 1'b0 || gOut(0) !== 0) begin bad++; $display("FAIL dup_clear got=%b/%0d want=0/0", err_dup[0], gOut(0)); end
  endtask

  task automatic test_same_cycle();
    setReq(0, 7, ASE_1CL);
    step();
    setRsp(0, 7);
    setReq(0, 7, ASE_1CL);
    step();
    total++; if (err_dup[0] !== 1'b0) begin bad++; $display("FAIL same_cycle_dup got=%b want=0", err_dup[0]); end
    total++; if (gOut(0) !== 1) begin bad++; $display("FAIL same_cycle_outst got=%0d want=1", gOut(0)); end
    setRsp(0, 7);
    step();
  endtask

  task automatic test_timeout();
    bit seen = 0;
    int seenTag = -1;
    setReq(0, 1, ASE_1CL);
    step();
    for (int i = 0; i < TIMEOUT_CYCLES + DEPTH + 4 && !seen; i++) begin
      step();
      if (err_timeout[0]) begin seen = 1; seenTag = gTag(0); end
    end
    total++; if (seen !== LAT_EN) begin bad++; $display("FAIL timeout_seen got=%b want=%b", seen, LAT_EN); end
    if (LAT_EN) begin
      total++; if (seenTag !== 1 || gOut(0) !== 0) begin bad++; $display("FAIL timeout_free tag=%0d outst=%0d want tag=1 outst=0", seenTag, gOut(0)); end
    end else begin
      setRsp(0, 1);
      step();
    end
    setReq(0, 10, ASE_2CL);
    setReq(1, 12, ASE_1CL);
    step();
    setReq(0, 11, ASE_3CL);
    step();
    total++; if (gOut(0) !== 2 || gOut(1) !== 1) begin bad++; $display("FAIL pre_reset_outst got=%0d/%0d want=2/1", gOut(0), gOut(1)); end
    SoftReset_n = 1'b0;
    step();
    total++; if (outstanding !== '0 || req_count !== '0 || rsp_count !== '0 || max_latency !== '0)
      begin bad++; $display("FAIL midreset_state outst=%h reqc=%h rspc=%h lat=%h want=0", outstanding, req_count, rsp_count, max_latency); end
    total++; if (idle !== 1'b1 || {err_dup, err_orphan, err_timeout} !== '0)
      begin bad++; $display("FAIL midreset_idle idle=%b errs=%b want=1/0", idle, {err_dup, err_orphan, err_timeout}); end
    SoftReset_n = 1'b1;
    setRsp(0, 10);
    step();
    total++; if (err_orphan[0] !== 1'b1 || gTag(0) !== 10) begin bad++; $display("FAIL post_reset_orphan got=%b tag=%0d want=1 tag=10", err_orphan[0], gTag(0)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 99) < 40) setReq(c, $urandom_range(0, 7), $urandom_range(0, 3));
        if ($urandom_range(0, 99) < 50) setRsp(c, $urandom_range(0, 7));
      end
      clear_stats = ($urandom_range(0, 49) == 0);
      step();
      for (int c = 0; c < NUM_CH; c++) begin
        total++; if (gOut(c) !== mOut(c)) begin bad++; $display("FAIL rnd_outst cyc%0d ch%0d got=%0d want=%0d", i, c, gOut(c), mOut(c)); end
        total++; if (gReqC(c) !== mReqCnt[c] || gRspC(c) !== mRspCnt[c])
          begin bad++; $display("FAIL rnd_counts cyc%0d ch%0d got=%0d/%0d want=%0d/%0d", i, c, gReqC(c), gRspC(c), mReqCnt[c], mRspCnt[c]); end
        total++; if (gLat(c) !== mMaxLat[c]) begin bad++; $display("FAIL rnd_maxlat cyc%0d ch%0d got=%0d want=%0d", i, c, gLat(c), mMaxLat[c]); end
        total++; if ({err_orphan[c], err_dup[c], err_timeout[c]} !== {mOrph[c], mDup[c], mTo[c]})
          begin bad++; $display("FAIL rnd_errs cyc%0d ch%0d got=%b%b%b want=%b%b%b", i, c, err_orphan[c], err_dup[c], err_timeout[c], mOrph[c], mDup[c], mTo[c]); end
        if (mOrph[c] || mDup[c] || mTo[c]) begin
          total++; if (gTag(c) !== mTag[c]) begin bad++; $display("FAIL rnd_errtag cyc%0d ch%0d got=%0d want=%0d", i, c, gTag(c), mTag[c]); end
        end
      end
      total++; if (idle !== (mOut(0) == 0 && mOut(1) == 0)) begin bad++; $display("FAIL rnd_idle cyc%0d got=%b", i, idle); end
    end
  endtask

  initial begin
    SoftReset_n = 1'b0;
    clear_stats = 1'b0;
    req_valid = '0; rsp_valid = '0;
    req_tag = '0; rsp_tag = '0; req_len = '0;
    mCyc = 0;
    test_reset();
    test_latency();
    test_multi_beat();
    test_errors();
    test_same_cycle();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
